reaction_ms_bcd: RTL



---
 rtl/reaction_pkg.sv | 44 ++++
 rtl/seq_divider32.sv | 74 +++++++
 rtl/reaction_ms_bcd.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction-time millisecond/BCD converter.
//   conv_state_t : converter FSM states
//   dbg_t        : debug view of the converter (FSM state, divider status)
//   BCD_DIGITS   : number of packed BCD digits on the display path
//   MS_BIN_W     : width of the clamped millisecond value fed to the BCD loop
//   bcd_add3     : one "add 3 to every nibble >= 5" pass of shift-add-3
// -----------------------------------------------------------------------------
package reaction_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int MS_BIN_W   = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIVIDE = 3'd1,
    CLAMP  = 3'd2,
    DABBLE = 3'd3,
    DONE   = 3'd4
  } conv_state_t;

  typedef struct packed {
    conv_state_t state;
    logic        div_busy;
    logic [32:0] div_rem;
  } dbg_t;

  // Applied before each shift so that a nibble which would reach >= 10
  // after doubling carries into the next digit instead.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_add3(
    input logic [4*BCD_DIGITS-1:0] acc
  );
    logic [4*BCD_DIGITS-1:0] res;
    res = acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (res[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = res[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_divider32.sv
// -----------------------------------------------------------------------------
// seq_divider32
// 32-bit by constant restoring divider, one quotient bit per clock, MSB first.
// A start while idle latches the dividend; 32 cycles later the quotient and
// remainder hold the result until the next start.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   start     : latch dividend and begin (ignored while busy)
//   dividend  : 32-bit unsigned dividend
//   busy      : a division is in progress
//   done      : the final quotient bit is being produced this cycle; quotient
//               and remainder are final from the next cycle on
//   quotient  : 32-bit quotient
//   remainder : 33-bit remainder (always < DIVISOR once finished)
// DIVISOR must be non-zero.
// -----------------------------------------------------------------------------
module seq_divider32 #(
  parameter logic [31:0] DIVISOR = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [32:0] remainder
);

  logic [31:0] r_dvd;
  logic [32:0] r_rem;
  logic [31:0] r_quot;
  logic [4:0]  r_cnt;
  logic        r_busy;

  logic [32:0] w_rem_shift;
  logic        w_fits;

  // Partial remainder is always < DIVISOR, so its low 32 bits plus the next
  // dividend bit hold the shifted value without loss.
  assign w_rem_shift = {r_rem[31:0], r_dvd[31]};
  assign w_fits      = (w_rem_shift >= {1'b0, DIVISOR});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_dvd  <= dividend;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= 5'd31;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd  <= {r_dvd[30:0], 1'b0};
      r_rem  <= w_fits ? (w_rem_shift - {1'b0, DIVISOR}) : w_rem_shift;
      r_quot <= {r_quot[30:0], w_fits};
      if (r_cnt == 5'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == 5'd0);
  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: rtl/reaction_ms_bcd.sv
// -----------------------------------------------------------------------------
// reaction_ms_bcd
// Converts a reaction time in clock cycles into whole milliseconds, clamps it
// at MAX_MS and publishes it as four packed BCD digits for the display mux.
// Fixed 50-cycle latency from accept to out_valid, one conversion per 51 cycles.
//
// Handshake: a value is taken on a rising edge where in_valid and in_ready are
// both high. in_ready is high only while idle; in_valid while busy is dropped,
// never queued. out_valid is a single-cycle pulse; bcd_ms/overflow hold their
// value until the next out_valid.
//
//   CLK100MHZ : clock
//   BTNU      : asynchronous active-high reset
//   in_valid  : cycles_in is valid
//   in_ready  : idle, can accept
//   cycles_in : reaction time in clock cycles (unsigned)
//   out_valid : one-cycle pulse, bcd_ms/overflow updated
//   bcd_ms    : {thousands, hundreds, tens, ones}
//   overflow  : last quotient exceeded MAX_MS
//   dbg       : FSM state and divider status for observation
// CYCLES_PER_MS must be >= 1; MAX_MS must be <= 9999.
// -----------------------------------------------------------------------------
module reaction_ms_bcd
  import reaction_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 100000,
  parameter int unsigned MAX_MS        = 9999
) (
  input  logic        CLK100MHZ,
  input  logic        BTNU,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cycles_in,
  output logic        out_valid,
  output logic [15:0] bcd_ms,
  output logic        overflow,
  output dbg_t        dbg
);

  // 14 shift-add-3 steps followed by 2 hold cycles keep the latency fixed.
  localparam int         DABBLE_PAD  = 2;
  localparam logic [3:0] DABBLE_LAST = 4'(MS_BIN_W + DABBLE_PAD - 1);

  conv_state_t             r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic                    r_ovf;
  logic                    r_ovf_next;
  logic [MS_BIN_W-1:0]     r_bin;
  logic [4*BCD_DIGITS-1:0] r_acc;
  logic [3:0]              r_cnt;

  logic                    w_start;
  logic                    w_div_busy;
  logic                    w_div_done;
  logic [31:0]             w_div_quot;
  logic [32:0]             w_div_rem;
  logic [4*BCD_DIGITS-1:0] w_acc_adj;

  // r_in_ready is high exactly while in IDLE, so this is the accept strobe.
  assign w_start   = in_valid && r_in_ready;
  assign w_acc_adj = bcd_add3(r_acc);

  seq_divider32 #(
    .DIVISOR (32'(CYCLES_PER_MS))
  ) u_div (
    .clk       (CLK100MHZ),
    .rst       (BTNU),
    .start     (w_start),
    .dividend  (cycles_in),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_quot),
    .remainder (w_div_rem)
  );

  always_ff @(posedge CLK100MHZ or posedge BTNU) begin
    if (BTNU) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_ovf_next  <= 1'b0;
      r_bin       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The divider latches cycles_in on this same edge.
          if (w_start) begin
            r_in_ready <= 1'b0;
            r_state    <= DIVIDE;
          end
        end

        DIVIDE: begin
          // Leave on the edge that produces the last quotient bit, so the
          // quotient is final throughout CLAMP.
          if (w_div_done) begin
            r_state <= CLAMP;
          end
        end

        CLAMP: begin
          if (w_div_quot > 32'(MAX_MS)) begin
            r_bin      <= MS_BIN_W'(MAX_MS);
            r_ovf_next <= 1'b1;
          end else begin
            r_bin      <= w_div_quot[MS_BIN_W-1:0];
            r_ovf_next <= 1'b0;
          end
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= DABBLE;
        end

        DABBLE: begin
          if (r_cnt < 4'(MS_BIN_W)) begin
            r_acc <= {w_acc_adj[4*BCD_DIGITS-2:0], r_bin[MS_BIN_W-1]};
            r_bin <= {r_bin[MS_BIN_W-2:0], 1'b0};
          end
          // Outputs are registered on the edge entering DONE so out_valid
          // is high for exactly the DONE cycle.
          if (r_cnt == DABBLE_LAST) begin
            r_bcd       <= r_acc;
            r_ovf       <= r_ovf_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        DONE: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bcd_ms    = r_bcd;
  assign overflow  = r_ovf;
  assign dbg       = '{state: r_state, div_busy: w_div_busy, div_rem: w_div_rem};

endmodule
